// File: rtl/ws_pkg.sv
// Types shared across the weight-stationary datapath: default widths, the psum/accumulator
// word types used with pe_array, and the psum_accumulator state encoding.
package ws_pkg;
  localparam int ACC_W_DEFAULT  = 32;
  localparam int PSUM_W_DEFAULT = 32;
  localparam int OUT_W_DEFAULT  = 8;

  typedef logic signed [ACC_W_DEFAULT-1:0]  acc_t;
  typedef logic signed [PSUM_W_DEFAULT-1:0] psum_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } psum_acc_state_t;
endpackage

// File: rtl/psum_accumulator_if.sv
// Psum write bus from pe_array plus the drained-result stream. The accumulator is the
// slave; master is the pe_array/consumer side.
interface psum_accumulator_if
  import ws_pkg::*;
#(
  parameter int NUM_COLS = 3,
  parameter int PSUM_W   = PSUM_W_DEFAULT,
  parameter int DEPTH    = 16,
  parameter int OUT_W    = OUT_W_DEFAULT
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_COLS);

  logic [NUM_COLS-1:0]             psum_valid;
  logic [NUM_COLS-1:0][AW-1:0]     psum_addr;
  logic [NUM_COLS-1:0][PSUM_W-1:0] psum_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [OUT_W-1:0]                out_data;
  logic [CW-1:0]                   out_col;
  logic [AW-1:0]                   out_idx;

  modport master (
    output psum_valid, psum_addr, psum_in, out_ready,
    input  out_valid, out_data, out_col, out_idx
  );

  modport slave (
    input  psum_valid, psum_addr, psum_in, out_ready,
    output out_valid, out_data, out_col, out_idx
  );
endinterface

// File: rtl/psum_post.sv
// Drain post-processing of one accumulator word: ReLU, right shift, unsigned saturate.
module psum_post
  import ws_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int OUT_W = OUT_W_DEFAULT,
  parameter int SW    = $clog2(ACC_W)
) (
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic [SW-1:0]           shift,
  output logic [OUT_W-1:0]        out_data
);
  logic [ACC_W-1:0] relu_val;
  logic [ACC_W-1:0] shifted;

  // After ReLU the value is non-negative, so a logical shift equals the arithmetic one.
  always_comb begin
    relu_val = acc_in[ACC_W-1] ? '0 : acc_in;
    shifted  = relu_val >> shift;
    if (|shifted[ACC_W-1:OUT_W]) out_data = '1;
    else                         out_data = shifted[OUT_W-1:0];
  end
endmodule

// File: rtl/psum_accumulator.sv
// Accumulates per-column psums across weight-tile passes into a flop bank, then drains
// post-processed results column-major over a valid/ready stream.
//
//   state | meaning
//   IDLE  | waiting for start; pass configuration latched on start
//   ACCUM | applying psum writes until every column has DEPTH writes
//   DRAIN | streaming post-processed entries (last pass only)
//   DONE  | one-cycle done pulse, then back to IDLE
module psum_accumulator
  import ws_pkg::*;
#(
  parameter int NUM_COLS = 3,
  parameter int PSUM_W   = PSUM_W_DEFAULT,
  parameter int ACC_W    = ACC_W_DEFAULT,
  parameter int DEPTH    = 16,
  parameter int OUT_W    = OUT_W_DEFAULT
) (
  input  logic                     clk100,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     first_pass,
  input  logic                     last_pass,
  input  logic [$clog2(ACC_W)-1:0] shift,
  output logic                     busy,
  output logic                     done,
  psum_accumulator_if.slave        bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(NUM_COLS);
  localparam int SW   = $clog2(ACC_W);
  localparam int CNTW = $clog2(DEPTH + 1);

  psum_acc_state_t state_q, state_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [SW-1:0]   shift_q, shift_d;

  logic [CNTW-1:0]         cnt_q [NUM_COLS];
  logic [CNTW-1:0]         cnt_d [NUM_COLS];
  logic signed [ACC_W-1:0] mem_q [NUM_COLS][DEPTH];
  logic signed [ACC_W-1:0] mem_d [NUM_COLS][DEPTH];
  logic                    all_full;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_col_q, out_col_d;
  logic [AW-1:0]    out_idx_q, out_idx_d;
  logic [CW-1:0]    rd_col;
  logic [AW-1:0]    rd_idx;
  logic             last_item;
  logic [OUT_W-1:0] post_data;

  // Bank reads come straight from mem_q, so back-to-back adds to one entry see the prior write.
  always_comb begin
    mem_d    = mem_q;
    all_full = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (state_q == ACCUM && bus.psum_valid[c] && cnt_q[c] != CNTW'(DEPTH)) begin
        if (first_q)
          mem_d[c][bus.psum_addr[c]] = ACC_W'($signed(bus.psum_in[c]));
        else
          mem_d[c][bus.psum_addr[c]] = mem_q[c][bus.psum_addr[c]]
                                       + ACC_W'($signed(bus.psum_in[c]));
        cnt_d[c] = cnt_q[c] + CNTW'(1);
      end
      if (state_q == IDLE && start) cnt_d[c] = '0;
      if (cnt_d[c] != CNTW'(DEPTH)) all_full = 1'b0;
    end
  end

  // Address of the entry to load into the output register: current one if the register
  // is empty, otherwise the next one in column-major order.
  always_comb begin
    last_item = (out_col_q == CW'(NUM_COLS - 1)) && (out_idx_q == AW'(DEPTH - 1));
    rd_col    = out_col_q;
    rd_idx    = out_idx_q;
    if (out_valid_q && !last_item) begin
      if (out_idx_q == AW'(DEPTH - 1)) begin
        rd_col = out_col_q + CW'(1);
        rd_idx = '0;
      end else begin
        rd_idx = out_idx_q + AW'(1);
      end
    end
  end

  psum_post #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SW(SW)) u_post (
    .acc_in   (mem_q[rd_col][rd_idx]),
    .shift    (shift_q),
    .out_data (post_data)
  );

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_d      = last_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          first_d = first_pass;
          last_d  = last_pass;
          shift_d = shift;
        end
      end
      ACCUM: begin
        if (all_full) state_d = last_q ? DRAIN : DONE;
      end
      DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = post_data;
        end else if (bus.out_ready) begin
          if (last_item) begin
            out_valid_d = 1'b0;
            out_col_d   = '0;
            out_idx_d   = '0;
            state_d     = DONE;
          end else begin
            out_col_d  = rd_col;
            out_idx_d  = rd_idx;
            out_data_d = post_data;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_idx_q   <= '0;
      for (int c = 0; c < NUM_COLS; c++) cnt_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_idx_q   <= out_idx_d;
      cnt_q       <= cnt_d;
    end
  end

  // Bank is intentionally not reset; a first_pass write defines every entry.
  always_ff @(posedge clk100) begin
    mem_q <= mem_d;
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_idx   = out_idx_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized scoreboard bench for psum_accumulator against an array-based reference model.
module tb_psum_accumulator;
  import ws_pkg::*;

  localparam int NC = 3;
  localparam int DP = 16;
  localparam int PW = 32;
  localparam int AWD = 32;
  localparam int OW = 8;

  logic       clk100 = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       first_pass = 1'b0;
  logic       last_pass = 1'b0;
  logic [4:0] shift = '0;
  logic       busy;
  logic       done;

  psum_accumulator_if #(.NUM_COLS(NC), .PSUM_W(PW), .DEPTH(DP), .OUT_W(OW)) bus ();

  psum_accumulator #(.NUM_COLS(NC), .PSUM_W(PW), .ACC_W(AWD), .DEPTH(DP), .OUT_W(OW)) dut (
    .clk100     (clk100),
    .rstn       (rstn),
    .start      (start),
    .first_pass (first_pass),
    .last_pass  (last_pass),
    .shift      (shift),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    int col;
    int idx;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   ref_mem[NC][DP];
  int   vals[NC][DP];
  int   q_addr[NC][$];
  int   q_val[NC][$];

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int pops = 0;
  int drains = 0;
  bit held = 1'b0;
  bit expect_done = 1'b0;
  logic [7:0] held_data;
  logic [1:0] held_col;
  logic [3:0] held_idx;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_post(input int v, input int sh);
    int r;
    if (v < 0) r = 0;
    else       r = v >>> sh;
    if (r > 255) r = 255;
    return r;
  endfunction

  function automatic int rand_val();
    if ($urandom_range(0, 1) == 1) return int'($urandom());
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  always begin
    @(posedge clk100);
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake, checks hold-while-stalled and done timing.
  always @(negedge clk100) begin
    if (!rstn) begin
      held = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        check("done_after_last_handshake", done, 1);
        check("out_valid_low_after_drain", bus.out_valid, 0);
        expect_done = 1'b0;
        drains++;
      end
      if (held) begin
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_data_stable", bus.out_data, held_data);
        check("stall_pos_stable", {bus.out_col, bus.out_idx}, {held_col, held_idx});
        held = 1'b0;
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            pops++;
            check("out_col", bus.out_col, e.col);
            check("out_idx", bus.out_idx, e.idx);
            check("out_data", bus.out_data, e.data);
            if (e.col == NC - 1 && e.idx == DP - 1) expect_done = 1'b1;
          end
        end else begin
          held      = 1'b1;
          held_data = bus.out_data;
          held_col  = bus.out_col;
          held_idx  = bus.out_idx;
        end
      end
    end
  end

  task automatic load_queues(input bit shuffle);
    for (int c = 0; c < NC; c++) begin
      int perm[DP];
      for (int i = 0; i < DP; i++) perm[i] = i;
      if (shuffle) begin
        for (int i = DP - 1; i > 0; i--) begin
          int j, t;
          j = int'($urandom_range(0, i));
          t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
      end
      q_addr[c].delete();
      q_val[c].delete();
      for (int i = 0; i < DP; i++) begin
        q_addr[c].push_back(perm[i]);
        q_val[c].push_back(vals[c][perm[i]]);
      end
    end
  endtask

  task automatic run_pass(input bit fp, input bit lp, input int sh, input bit gaps,
                          input bit stray, input int abort_after);
    int  k = 0;
    bit  pending;
    bit  stray_done = 1'b0;
    bit  col0_empty;
    int  d0, p0, n;
    @(posedge clk100); #1;
    start      = 1'b1;
    first_pass = fp;
    last_pass  = lp;
    shift      = 5'(sh);
    bus.psum_valid   = 3'b001;
    bus.psum_addr[0] = '0;
    bus.psum_in[0]   = 32'd999;
    @(posedge clk100); #1;
    start = 1'b0;
    bus.psum_valid = '0;
    check("busy_after_start", busy, 1);
    do begin
      bus.psum_valid = '0;
      start = (k == 3);
      col0_empty = (q_addr[0].size() == 0);
      for (int c = 0; c < NC; c++) begin
        if (k >= c && q_addr[c].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          int a, v;
          a = q_addr[c].pop_front();
          v = q_val[c].pop_front();
          bus.psum_valid[c] = 1'b1;
          bus.psum_addr[c]  = 4'(a);
          bus.psum_in[c]    = v;
          if (fp) ref_mem[c][a] = v;
          else    ref_mem[c][a] = ref_mem[c][a] + v;
        end
      end
      if (stray && !stray_done && col0_empty && q_addr[NC-1].size() > 0) begin
        bus.psum_valid[0] = 1'b1;
        bus.psum_addr[0]  = '0;
        bus.psum_in[0]    = 32'd1000;
        stray_done = 1'b1;
      end
      pending = 1'b0;
      for (int c = 0; c < NC; c++) if (q_addr[c].size() > 0) pending = 1'b1;
      @(posedge clk100); #1;
      k++;
    end while (pending);
    bus.psum_valid = '0;
    start = 1'b0;
    @(negedge clk100);
    if (!lp) begin
      check("done_pulse_nonlast", done, 1);
      check("no_out_valid_nonlast", bus.out_valid, 0);
      @(negedge clk100);
      check("done_cleared", done, 0);
      check("busy_cleared", busy, 0);
    end else begin
      check("drain_entry_out_valid", bus.out_valid, 0);
      check("drain_entry_busy", busy, 1);
      for (int c = 0; c < NC; c++)
        for (int i = 0; i < DP; i++)
          exp_q.push_back('{col: c, idx: i, data: ref_post(ref_mem[c][i], sh)});
      @(negedge clk100);
      check("first_out_valid", bus.out_valid, 1);
      if (abort_after > 0) begin
        p0 = pops;
        for (n = 0; n < 500 && pops < p0 + abort_after; n++) @(negedge clk100);
        check("abort_point_reached", (pops >= p0 + abort_after) ? 1 : 0, 1);
        @(posedge clk100); #2;
        rstn = 1'b0;
        #1;
        check("reset_mid_out_valid", bus.out_valid, 0);
        check("reset_mid_busy", busy, 0);
        check("reset_mid_done", done, 0);
        exp_q.delete();
        repeat (2) @(posedge clk100);
        #3;
        rstn = 1'b1;
      end else begin
        d0 = drains;
        for (n = 0; n < 1000 && drains == d0; n++) @(negedge clk100);
        check("drain_completed", drains - d0, 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.psum_valid = '0;
    bus.psum_addr  = '0;
    bus.psum_in    = '0;
    bus.out_ready  = 1'b1;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_col", bus.out_col, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk100);
    rstn = 1'b1;

    // single tile, first and last pass
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = 10 * c + i;
    load_queues(1'b0);
    run_pass(1'b1, 1'b1, 0, 1'b0, 1'b0, 0);

    // two-pass accumulation: 100 then -30, shift 1
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = 100;
    load_queues(1'b1);
    run_pass(1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = -30;
    load_queues(1'b1);
    run_pass(1'b0, 1'b1, 1, 1'b1, 1'b0, 0);

    // post-processing boundaries
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = rand_val();
    vals[0][0] = -5;
    vals[0][1] = 255;
    vals[0][2] = 256;
    vals[0][3] = 32'h7FFF_FFFF;
    vals[0][4] = 32'h8000_0000;
    load_queues(1'b1);
    run_pass(1'b1, 1'b1, 0, 1'b1, 1'b0, 0);

    // backpressure with out_ready toggling
    ready_mode = 1;
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = rand_val();
    load_queues(1'b1);
    run_pass(1'b1, 1'b1, 2, 1'b0, 1'b0, 0);
    ready_mode = 0;

    // skewed columns, back-to-back duplicate 3 then 4 onto 0, stray valid after saturation
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = 0;
    load_queues(1'b0);
    run_pass(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = int'($urandom_range(0, 50));
    load_queues(1'b0);
    q_addr[0].delete();
    q_val[0].delete();
    for (int i = 0; i < DP - 1; i++) begin
      if (i == 5) begin
        q_addr[0].push_back(5); q_val[0].push_back(3);
        q_addr[0].push_back(5); q_val[0].push_back(4);
      end else begin
        q_addr[0].push_back(i); q_val[0].push_back(vals[0][i]);
      end
    end
    run_pass(1'b0, 1'b1, 0, 1'b0, 1'b1, 0);

    // reset in the middle of a drain, then a fresh run
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = rand_val();
    load_queues(1'b1);
    run_pass(1'b1, 1'b1, 0, 1'b0, 1'b0, 10);
    for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = rand_val();
    load_queues(1'b1);
    run_pass(1'b1, 1'b1, 1, 1'b1, 1'b0, 0);

    // randomized multi-pass runs with random backpressure
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      int np, sh;
      np = int'($urandom_range(1, 3));
      sh = int'($urandom_range(0, 31));
      for (int p = 0; p < np; p++) begin
        for (int c = 0; c < NC; c++) for (int i = 0; i < DP; i++) vals[c][i] = rand_val();
        load_queues(1'b1);
        run_pass(p == 0, p == np - 1, sh, 1'b1, 1'b0, 0);
      end
    end
    ready_mode = 0;

    repeat (3) @(negedge clk100);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
